// File: rtl/copperv_core.sv
// copperv_core: multicycle RV32I core, one instruction in flight (FETCH -> EXEC [-> MEM]).
// Two Wishbone-classic masters: instruction fetch (inst_*) and load/store (data_*).
// Optional feature macro: COPPERV_ILLEGAL_HALT_EN
//   defined   - an illegal or misaligned instruction stops the core and raises halted.
//   undefined - an illegal instruction retires as a NOP and halted is tied 0.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   inst_adr/datwr/we/sel/stb/cyc  fetch master outputs (read-only, adr = PC)
//   inst_datrd, inst_ack           fetched word and completion
//   data_adr/datwr/we/sel/stb/cyc  load/store master outputs (word address, lane enables)
//   data_datrd, data_ack           load data and completion
//   halted                         core stopped
module copperv_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_adr,
  output logic [31:0] inst_datwr,
  output logic        inst_we,
  output logic [3:0]  inst_sel,
  output logic        inst_stb,
  output logic        inst_cyc,
  input  logic [31:0] inst_datrd,
  input  logic        inst_ack,
  output logic [31:0] data_adr,
  output logic [31:0] data_datwr,
  output logic        data_we,
  output logic [3:0]  data_sel,
  output logic        data_stb,
  output logic        data_cyc,
  input  logic [31:0] data_datrd,
  input  logic        data_ack,
  output logic        halted
);

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcReg    = 7'b0110011;

  typedef enum logic [1:0] {StFetch, StExec, StMem, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        inst_stb_q, inst_stb_d;
  logic        data_stb_q, data_stb_d;
  logic        data_we_q, data_we_d;
  logic [3:0]  data_sel_q, data_sel_d;
  logic [31:0] data_adr_q, data_adr_d;
  logic [31:0] data_datwr_q, data_datwr_d;
`ifdef COPPERV_ILLEGAL_HALT_EN
  logic        halted_q, halted_d;
`endif

  // x0 is held at zero by never writing it, so reads need no special case.
  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  // Decode fields
  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, pc_plus4;

  assign opcode  = ir_q[6:0];
  assign rd      = ir_q[11:7];
  assign f3      = ir_q[14:12];
  assign rs1     = ir_q[19:15];
  assign rs2     = ir_q[24:20];
  assign f7      = ir_q[31:25];
  assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u   = {ir_q[31:12], 12'b0};
  assign imm_j   = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign rs1_val = rf_q[rs1];
  assign rs2_val = rf_q[rs2];
  assign pc_plus4 = pc_q + 32'd4;

  logic        legal, is_mem, is_store, misaligned, illegal, writes_rd, taken;
  logic [31:0] alu_b, alu_out, sra_out, ea, target_raw, next_pc, wb_data;
  logic [31:0] lane_data, load_val, st_data;
  logic [4:0]  shamt;
  logic [3:0]  lane_sel;

  assign alu_b   = (opcode == OpcReg) ? rs2_val : imm_i;
  assign shamt   = alu_b[4:0];
  assign sra_out = $unsigned($signed(rs1_val) >>> shamt);

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OpcLui, OpcAuipc, OpcJal: legal = 1'b1;
      OpcJalr:   legal = (f3 == 3'd0);
      OpcBranch: legal = (f3[2:1] != 2'b01);
      OpcLoad:   legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      OpcStore:  legal = (f3 inside {3'd0, 3'd1, 3'd2});
      OpcImm: begin
        if (f3 == 3'd1)      legal = (f7 == 7'h00);
        else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
        else                 legal = 1'b1;
      end
      OpcReg:    legal = (f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5));
      default:   legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_out = '0;
    case (f3)
      3'd0: alu_out = (opcode == OpcReg && f7[5]) ? rs1_val - alu_b : rs1_val + alu_b;
      3'd1: alu_out = rs1_val << shamt;
      3'd2: alu_out = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      3'd3: alu_out = {31'b0, rs1_val < alu_b};
      3'd4: alu_out = rs1_val ^ alu_b;
      3'd5: alu_out = f7[5] ? sra_out : rs1_val >> shamt;
      3'd6: alu_out = rs1_val | alu_b;
      3'd7: alu_out = rs1_val & alu_b;
      default: alu_out = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (f3)
      3'd0: taken = (rs1_val == rs2_val);
      3'd1: taken = (rs1_val != rs2_val);
      3'd4: taken = ($signed(rs1_val) < $signed(rs2_val));
      3'd5: taken = !($signed(rs1_val) < $signed(rs2_val));
      3'd6: taken = (rs1_val < rs2_val);
      3'd7: taken = !(rs1_val < rs2_val);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    if (opcode == OpcJal)                     target_raw = pc_q + imm_j;
    else if (opcode == OpcJalr)               target_raw = rs1_val + imm_i;
    else if (opcode == OpcBranch && taken)    target_raw = pc_q + imm_b;
    else                                      target_raw = pc_plus4;
    // Clearing bits [1:0] also covers the JALR &~1 rule.
    next_pc = {target_raw[31:2], 2'b00};

    case (opcode)
      OpcLui:          wb_data = imm_u;
      OpcAuipc:        wb_data = pc_q + imm_u;
      OpcJal, OpcJalr: wb_data = pc_plus4;
      default:         wb_data = alu_out;
    endcase
    writes_rd = opcode inside {OpcLui, OpcAuipc, OpcJal, OpcJalr, OpcImm, OpcReg};
  end

  // Memory access: the effective address is recomputed in MEM too; rs1 cannot change meanwhile.
  always_comb begin
    is_store   = (opcode == OpcStore);
    is_mem     = (opcode == OpcLoad) || is_store;
    ea         = rs1_val + (is_store ? imm_s : imm_i);
    misaligned = is_mem && (((f3[1:0] == 2'd1) && ea[0]) ||
                            ((f3[1:0] == 2'd2) && (ea[1:0] != 2'd0)));
    illegal    = !legal || misaligned;

    case (f3[1:0])
      2'd0:    begin lane_sel = 4'b0001 << ea[1:0];           st_data = {4{rs2_val[7:0]}};  end
      2'd1:    begin lane_sel = ea[1] ? 4'hC : 4'h3;           st_data = {2{rs2_val[15:0]}}; end
      default: begin lane_sel = 4'hF;                          st_data = rs2_val;            end
    endcase

    lane_data = data_datrd >> {ea[1:0], 3'b000};
    case (f3)
      3'd0:    load_val = {{24{lane_data[7]}}, lane_data[7:0]};
      3'd1:    load_val = {{16{lane_data[15]}}, lane_data[15:0]};
      3'd4:    load_val = {24'b0, lane_data[7:0]};
      3'd5:    load_val = {16'b0, lane_data[15:0]};
      default: load_val = lane_data;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    inst_stb_d   = inst_stb_q;
    data_stb_d   = data_stb_q;
    data_we_d    = data_we_q;
    data_sel_d   = data_sel_q;
    data_adr_d   = data_adr_q;
    data_datwr_d = data_datwr_q;
`ifdef COPPERV_ILLEGAL_HALT_EN
    halted_d     = halted_q;
`endif
    rf_we        = 1'b0;
    rf_waddr     = rd;
    rf_wdata     = wb_data;

    unique case (state_q)
      StFetch: begin
        if (!inst_stb_q) begin
          // First fetch after reset release opens its cycle here.
          inst_stb_d = 1'b1;
        end else if (inst_ack) begin
          ir_d       = inst_datrd;
          inst_stb_d = 1'b0;
          state_d    = StExec;
        end
      end
      StExec: begin
        if (illegal) begin
`ifdef COPPERV_ILLEGAL_HALT_EN
          halted_d   = 1'b1;
          state_d    = StHalt;
`else
          pc_d       = pc_plus4;
          inst_stb_d = 1'b1;
          state_d    = StFetch;
`endif
        end else if (is_mem) begin
          data_stb_d   = 1'b1;
          data_we_d    = is_store;
          data_sel_d   = lane_sel;
          data_adr_d   = {ea[31:2], 2'b00};
          data_datwr_d = is_store ? st_data : '0;
          state_d      = StMem;
        end else begin
          rf_we      = writes_rd;
          pc_d       = next_pc;
          inst_stb_d = 1'b1;
          state_d    = StFetch;
        end
      end
      StMem: begin
        if (data_stb_q && data_ack) begin
          rf_we        = !is_store;
          rf_wdata     = load_val;
          data_stb_d   = 1'b0;
          data_we_d    = 1'b0;
          data_sel_d   = '0;
          data_adr_d   = '0;
          data_datwr_d = '0;
          pc_d         = pc_plus4;
          inst_stb_d   = 1'b1;
          state_d      = StFetch;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StFetch;
      pc_q         <= {RESET_PC[31:2], 2'b00};
      ir_q         <= '0;
      inst_stb_q   <= 1'b0;
      data_stb_q   <= 1'b0;
      data_we_q    <= 1'b0;
      data_sel_q   <= '0;
      data_adr_q   <= '0;
      data_datwr_q <= '0;
`ifdef COPPERV_ILLEGAL_HALT_EN
      halted_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      inst_stb_q   <= inst_stb_d;
      data_stb_q   <= data_stb_d;
      data_we_q    <= data_we_d;
      data_sel_q   <= data_sel_d;
      data_adr_q   <= data_adr_d;
      data_datwr_q <= data_datwr_d;
`ifdef COPPERV_ILLEGAL_HALT_EN
      halted_q     <= halted_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign inst_adr   = inst_stb_q ? pc_q : '0;
  assign inst_datwr = '0;
  assign inst_we    = 1'b0;
  assign inst_sel   = {4{inst_stb_q}};
  assign inst_stb   = inst_stb_q;
  assign inst_cyc   = inst_stb_q;
  assign data_adr   = data_adr_q;
  assign data_datwr = data_datwr_q;
  assign data_we    = data_we_q;
  assign data_sel   = data_sel_q;
  assign data_stb   = data_stb_q;
  assign data_cyc   = data_stb_q;
`ifdef COPPERV_ILLEGAL_HALT_EN
  assign halted     = halted_q;
`else
  assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_copperv_core.sv
// Scoreboard bench for copperv_core: expected bus transactions are queued up front and a monitor
// pops and compares each transaction as the core opens it.
module tb_copperv_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_adr, inst_datwr, inst_datrd;
  logic        inst_we, inst_stb, inst_cyc, inst_ack;
  logic [3:0]  inst_sel;
  logic [31:0] data_adr, data_datwr, data_datrd;
  logic        data_we, data_stb, data_cyc, data_ack;
  logic [3:0]  data_sel;
  logic        halted;

  always #5 clk = ~clk;

  copperv_core #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .inst_adr(inst_adr), .inst_datwr(inst_datwr), .inst_we(inst_we), .inst_sel(inst_sel),
    .inst_stb(inst_stb), .inst_cyc(inst_cyc), .inst_datrd(inst_datrd), .inst_ack(inst_ack),
    .data_adr(data_adr), .data_datwr(data_datwr), .data_we(data_we), .data_sel(data_sel),
    .data_stb(data_stb), .data_cyc(data_cyc), .data_datrd(data_datrd), .data_ack(data_ack),
    .halted(halted)
  );

  typedef struct {
    bit          is_data;
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdat;
    bit          chk_wdat;
  } txn_t;

  txn_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          txn_idx = 0;
  bit          sb_open = 0;
  logic [31:0] imem [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic push_f(input logic [31:0] a);
    txn_t t;
    t.is_data = 0; t.adr = a; t.we = 0; t.sel = 4'hF; t.wdat = '0; t.chk_wdat = 1;
    exp_q.push_back(t);
  endtask

  task automatic push_st(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    txn_t t;
    t.is_data = 1; t.adr = a; t.we = 1; t.sel = s; t.wdat = d; t.chk_wdat = 1;
    exp_q.push_back(t);
  endtask

  task automatic push_ld(input logic [31:0] a, input logic [3:0] s);
    txn_t t;
    t.is_data = 1; t.adr = a; t.we = 0; t.sel = s; t.wdat = '0; t.chk_wdat = 0;
    exp_q.push_back(t);
  endtask

  task automatic observe(input bit is_data, input logic [31:0] adr, input logic we,
                         input logic [3:0] sel, input logic [31:0] wdat);
    txn_t t;
    if (exp_q.size() == 0) begin
      if (sb_open) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected %s txn: got adr 0x%08h, required no access",
                 is_data ? "data" : "fetch", adr);
      end
    end else begin
      t = exp_q.pop_front();
      check($sformatf("txn%0d is_data", txn_idx), {31'b0, is_data}, {31'b0, t.is_data});
      check($sformatf("txn%0d adr", txn_idx), adr, t.adr);
      check($sformatf("txn%0d we", txn_idx), {31'b0, we}, {31'b0, t.we});
      check($sformatf("txn%0d sel", txn_idx), {28'b0, sel}, {28'b0, t.sel});
      if (t.chk_wdat) check($sformatf("txn%0d datwr", txn_idx), wdat, t.wdat);
      txn_idx++;
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) @(negedge clk);
    check("outstanding txns after budget", exp_q.size(), 0);
  endtask

  // Instruction slave: zero wait states, except the first fetch of 0x4 stalls for 20 cycles.
  int inst_wait = 0;
  bit stalled   = 0;
  initial begin
    inst_ack = 1'b0;
    inst_datrd = '0;
    forever begin
      @(posedge clk);
      #1;
      inst_ack = 1'b0;
      if (rst && inst_stb) begin
        if (inst_wait >= ((inst_adr == 32'h4 && !stalled) ? 20 : 0)) begin
          inst_ack   = 1'b1;
          inst_datrd = imem[inst_adr[7:2]];
          inst_wait  = 0;
          if (inst_adr == 32'h4) stalled = 1;
        end else begin
          inst_wait++;
        end
      end else begin
        inst_wait = 0;
      end
    end
  end

  // Data slave: one wait state, loads always return 0x80000000.
  int data_wait = 0;
  initial begin
    data_ack = 1'b0;
    data_datrd = '0;
    forever begin
      @(posedge clk);
      #1;
      data_ack = 1'b0;
      if (rst && data_stb) begin
        if (data_wait >= 1) begin
          data_ack   = 1'b1;
          data_datrd = 32'h8000_0000;
          data_wait  = 0;
        end else begin
          data_wait++;
        end
      end else begin
        data_wait = 0;
      end
    end
  end

  // Monitor: a transaction starts when stb is seen high after being low or after an ack.
  logic        i_prev = 0, i_ackp = 0, d_prev = 0, d_ackp = 0;
  logic [31:0] cap_adr = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        i_prev = 0; i_ackp = 0; d_prev = 0; d_ackp = 0;
      end else begin
        if (inst_stb && (!i_prev || i_ackp)) begin
          observe(0, inst_adr, inst_we, inst_sel, inst_datwr);
          check("inst_cyc follows inst_stb", {31'b0, inst_cyc}, {31'b0, inst_stb});
          cap_adr = inst_adr;
        end else if (inst_stb) begin
          check("fetch hold adr", inst_adr, cap_adr);
          check("fetch hold sel/cyc", {27'b0, inst_sel, inst_cyc}, 32'h1F);
        end
        if (data_stb && (!d_prev || d_ackp)) begin
          observe(1, data_adr, data_we, data_sel, data_datwr);
          check("data_cyc follows data_stb", {31'b0, data_cyc}, {31'b0, data_stb});
        end
        i_prev = inst_stb; i_ackp = inst_ack;
        d_prev = data_stb; d_ackp = data_ack;
      end
    end
  end

  initial begin
    bit seen;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    imem[0]  = 32'h0000_0001; // 0x00 illegal opcode
    imem[1]  = 32'h0050_0093; // 0x04 ADDI x1,x0,5
    imem[2]  = 32'h1010_2023; // 0x08 SW   x1,0x100(x0)
    imem[3]  = 32'h0AB0_0093; // 0x0C ADDI x1,x0,0xAB
    imem[4]  = 32'h1010_01A3; // 0x10 SB   x1,0x103(x0)
    imem[5]  = 32'h1030_0103; // 0x14 LB   x2,0x103(x0)
    imem[6]  = 32'h1030_4183; // 0x18 LBU  x3,0x103(x0)
    imem[7]  = 32'h1020_2223; // 0x1C SW   x2,0x104(x0)
    imem[8]  = 32'h1030_2423; // 0x20 SW   x3,0x108(x0)
    imem[9]  = 32'h0000_0463; // 0x24 BEQ  x0,x0,+8
    imem[10] = 32'h0100_006F; // 0x28 JAL  x0,+16
    imem[11] = 32'hFFDF_F0EF; // 0x2C JAL  x1,-4
    imem[14] = 32'h1010_2623; // 0x38 SW   x1,0x10C(x0)
    imem[15] = 32'h0000_1463; // 0x3C BNE  x0,x0,+8 (not taken)
    imem[16] = 32'hFF00_0293; // 0x40 ADDI x5,x0,-16
    imem[17] = 32'h4022_D313; // 0x44 SRAI x6,x5,2
    imem[18] = 32'h1060_2823; // 0x48 SW   x6,0x110(x0)
    imem[19] = 32'h0050_33B3; // 0x4C SLTU x7,x0,x5
    imem[20] = 32'h1070_2A23; // 0x50 SW   x7,0x114(x0)
    imem[21] = 32'h1010_2403; // 0x54 LW   x8,0x101(x0) misaligned
    imem[22] = 32'h0000_006F; // 0x58 JAL  x0,0 (spin)

    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset inst ctl", {25'b0, inst_stb, inst_cyc, inst_we, inst_sel}, 32'h0);
    check("reset inst_adr", inst_adr, 32'h0);
    check("reset data ctl", {25'b0, data_stb, data_cyc, data_we, data_sel}, 32'h0);
    check("reset data_adr", data_adr, 32'h0);
    check("reset data_datwr", data_datwr, 32'h0);
    check("reset halted", {31'b0, halted}, 32'h0);

`ifdef COPPERV_ILLEGAL_HALT_EN
    push_f(32'h00);
`else
    push_f(32'h00); push_f(32'h04); push_f(32'h08);
    push_st(32'h100, 4'hF, 32'h0000_0005);
    push_f(32'h0C); push_f(32'h10);
    push_st(32'h100, 4'h8, 32'hABAB_ABAB);
    push_f(32'h14); push_ld(32'h100, 4'h8);
    push_f(32'h18); push_ld(32'h100, 4'h8);
    push_f(32'h1C); push_st(32'h104, 4'hF, 32'hFFFF_FF80);
    push_f(32'h20); push_st(32'h108, 4'hF, 32'h0000_0080);
    push_f(32'h24); push_f(32'h2C); push_f(32'h28); push_f(32'h38);
    push_st(32'h10C, 4'hF, 32'h0000_0030);
    push_f(32'h3C); push_f(32'h40); push_f(32'h44); push_f(32'h48);
    push_st(32'h110, 4'hF, 32'hFFFF_FFFC);
    push_f(32'h4C); push_f(32'h50);
    push_st(32'h114, 4'hF, 32'h0000_0001);
    push_f(32'h54); push_f(32'h58);
`endif
    sb_open = 1;
    rst = 1'b1;

    seen = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      if (inst_stb) seen = 1;
    end
    check("fetch strobe by 2nd edge after release", {31'b0, seen}, 32'h1);

    wait_drain(2000);
`ifdef COPPERV_ILLEGAL_HALT_EN
    repeat (30) @(negedge clk);
    check("halted after illegal", {31'b0, halted}, 32'h1);
`endif
    sb_open = 0;

    // Reset in the middle of an open fetch.
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (inst_stb) seen = 1;
    end
`ifndef COPPERV_ILLEGAL_HALT_EN
    check("spin fetch open before mid-fetch reset", {31'b0, seen}, 32'h1);
`endif
    #2;
    rst = 1'b0;
    #1;
    check("mid-fetch reset drops strobes", {28'b0, inst_stb, inst_cyc, data_stb, data_cyc},
          32'h0);
    check("halted cleared by reset", {31'b0, halted}, 32'h0);
    push_f(32'h00);
    sb_open = 1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_drain(50);
    sb_open = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
